// File: rtl/lenet_l1_pkg.sv
// Shared types and defaults for the LeNet layer-1 datapath.
package lenet_l1_pkg;

   localparam int unsigned L1_IMG_W = 32;
   localparam int unsigned L1_IMG_H = 32;
   localparam int unsigned L1_K     = 5;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } cwr_state_t;

   // Width of a counter holding values 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_win_addr_gen.sv
// Window/kernel counters and incremental RAM address for a raster walk of every KxK window.
module conv_win_addr_gen
   import lenet_l1_pkg::*;
#(
   parameter int unsigned IMG_W     = L1_IMG_W,
   parameter int unsigned IMG_H     = L1_IMG_H,
   parameter int unsigned K         = L1_K,
   parameter int unsigned RAM_ADDRW = 10
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear,
   input  logic                 step,
   output logic [RAM_ADDRW-1:0] addr,
   output logic                 last_win,
   output logic                 last_frame
);

   localparam int unsigned ORW = cnt_w(IMG_H - K + 1);
   localparam int unsigned OCW = cnt_w(IMG_W - K + 1);
   localparam int unsigned KW  = cnt_w(K);

   localparam logic [ORW-1:0]       OROW_MAX = ORW'(IMG_H - K);
   localparam logic [OCW-1:0]       OCOL_MAX = OCW'(IMG_W - K);
   localparam logic [KW-1:0]        K_MAX    = KW'(K - 1);
   localparam logic [RAM_ADDRW-1:0] W_A      = RAM_ADDRW'(IMG_W);
   localparam logic [RAM_ADDRW-1:0] K_A      = RAM_ADDRW'(K);
   localparam logic [RAM_ADDRW-1:0] ONE_A    = RAM_ADDRW'(1);

   logic [ORW-1:0]       out_row;
   logic [OCW-1:0]       out_col;
   logic [KW-1:0]        k_row;
   logic [KW-1:0]        k_col;
   logic [RAM_ADDRW-1:0] base;
   logic [RAM_ADDRW-1:0] row_off;

   logic k_col_end, k_row_end, out_col_end, out_row_end;

   assign k_col_end   = (k_col == K_MAX);
   assign k_row_end   = (k_row == K_MAX);
   assign out_col_end = (out_col == OCOL_MAX);
   assign out_row_end = (out_row == OROW_MAX);

   assign last_win   = k_col_end && k_row_end;
   assign last_frame = last_win && out_col_end && out_row_end;

   // base tracks out_row*IMG_W + out_col, row_off tracks k_row*IMG_W.
   assign addr = base + row_off + RAM_ADDRW'(k_col);

   always_ff @(posedge clk_i) begin
      if (rst_i || clear) begin
         out_row <= '0;
         out_col <= '0;
         k_row   <= '0;
         k_col   <= '0;
         base    <= '0;
         row_off <= '0;
      end else if (step) begin
         if (!k_col_end) begin
            k_col <= k_col + 1'b1;
         end else begin
            k_col <= '0;
            if (!k_row_end) begin
               k_row   <= k_row + 1'b1;
               row_off <= row_off + W_A;
            end else begin
               k_row   <= '0;
               row_off <= '0;
               if (!out_col_end) begin
                  out_col <= out_col + 1'b1;
                  base    <= base + ONE_A;
               end else begin
                  out_col <= '0;
                  if (!out_row_end) begin
                     out_row <= out_row + 1'b1;
                     // From column IMG_W-K back to column 0 of the next row.
                     base    <= base + K_A;
                  end else begin
                     out_row <= '0;
                     base    <= '0;
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/conv_win_reader.sv
// Layer-1 feature-map reader: streams every KxK window of the image to the MAC array.
module conv_win_reader
   import lenet_l1_pkg::*;
#(
   parameter int unsigned IMG_W     = L1_IMG_W,
   parameter int unsigned IMG_H     = L1_IMG_H,
   parameter int unsigned K         = L1_K,
   parameter int unsigned RAM_ADDRW = 10,
   parameter int unsigned RAM_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [RAM_ADDRW-1:0] ram_rd_addr_o,
   input  logic [RAM_WIDTH-1:0] ram_rd_data_i,
   output logic                 pix_valid_o,
   input  logic                 pix_ready_i,
   output logic [RAM_WIDTH-1:0] pix_data_o,
   output logic                 pix_last_win_o,
   output logic                 pix_last_frame_o
);

   if ($clog2(IMG_W * IMG_H) > RAM_ADDRW) begin : g_addrw_chk
      $error("conv_win_reader: RAM_ADDRW too narrow for IMG_W*IMG_H");
   end
   if (K == 0 || K > IMG_W || K > IMG_H) begin : g_k_chk
      $error("conv_win_reader: K must be in 1..min(IMG_W, IMG_H)");
   end

   cwr_state_t state;
   logic       adv, step, clear;
   logic       last_win, last_frame;

   assign adv   = !pix_valid_o || pix_ready_i;
   // Counters sit at zero in IDLE, which also keeps the read address at 0.
   assign clear = (state == StIdle);
   assign step  = (state == StRun) && adv;

   conv_win_addr_gen #(
      .IMG_W     (IMG_W),
      .IMG_H     (IMG_H),
      .K         (K),
      .RAM_ADDRW (RAM_ADDRW)
   ) u_addr_gen (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear      (clear),
      .step       (step),
      .addr       (ram_rd_addr_o),
      .last_win   (last_win),
      .last_frame (last_frame)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state            <= StIdle;
         busy_o           <= 1'b0;
         done_o           <= 1'b0;
         pix_valid_o      <= 1'b0;
         pix_data_o       <= '0;
         pix_last_win_o   <= 1'b0;
         pix_last_frame_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start_i) begin
                  state  <= StRun;
                  busy_o <= 1'b1;
               end
            end
            StRun: begin
               if (adv) begin
                  pix_data_o       <= ram_rd_data_i;
                  pix_valid_o      <= 1'b1;
                  pix_last_win_o   <= last_win;
                  pix_last_frame_o <= last_frame;
                  if (last_frame) state <= StDrain;
               end
            end
            StDrain: begin
               if (pix_valid_o && pix_ready_i) begin
                  pix_valid_o <= 1'b0;
                  done_o      <= 1'b1;
                  busy_o      <= 1'b0;
                  state       <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_win_reader.sv
// Bench for conv_win_reader: a 6x6/K=5 instance with a scoreboard, plus a default-size instance.
module tb_conv_win_reader;

   localparam int unsigned SW   = 6;
   localparam int unsigned SH   = 6;
   localparam int unsigned SK   = 5;
   localparam int unsigned SAW  = 6;
   localparam int unsigned DAW  = 10;
   localparam int unsigned DW   = 32;
   localparam int          SPIX = (SH - SK + 1) * (SW - SK + 1) * SK * SK;
   localparam int          DPIX = 19600;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   logic           rst = 1'b1;
   logic           s_start = 1'b0, s_ready = 1'b0;
   logic           s_busy, s_done, s_valid, s_lw, s_lf;
   logic [SAW-1:0] s_addr;
   logic [DW-1:0]  s_rdata, s_data;

   logic           d_start = 1'b0, d_ready = 1'b1;
   logic           d_busy, d_done, d_valid, d_lw, d_lf;
   logic [DAW-1:0] d_addr;
   logic [DW-1:0]  d_rdata, d_data;

   // RAMs preloaded with data = address.
   assign s_rdata = DW'(s_addr);
   assign d_rdata = DW'(d_addr);

   logic [DW+1:0] exp_q[$];
   logic [DW-1:0] rx_data[SPIX];

   conv_win_reader #(
      .IMG_W     (SW),
      .IMG_H     (SH),
      .K         (SK),
      .RAM_ADDRW (SAW),
      .RAM_WIDTH (DW)
   ) dut_s (
      .clk_i            (clk),
      .rst_i            (rst),
      .start_i          (s_start),
      .busy_o           (s_busy),
      .done_o           (s_done),
      .ram_rd_addr_o    (s_addr),
      .ram_rd_data_i    (s_rdata),
      .pix_valid_o      (s_valid),
      .pix_ready_i      (s_ready),
      .pix_data_o       (s_data),
      .pix_last_win_o   (s_lw),
      .pix_last_frame_o (s_lf)
   );

   conv_win_reader dut_d (
      .clk_i            (clk),
      .rst_i            (rst),
      .start_i          (d_start),
      .busy_o           (d_busy),
      .done_o           (d_done),
      .ram_rd_addr_o    (d_addr),
      .ram_rd_data_i    (d_rdata),
      .pix_valid_o      (d_valid),
      .pix_ready_i      (d_ready),
      .pix_data_o       (d_data),
      .pix_last_win_o   (d_lw),
      .pix_last_frame_o (d_lf)
   );

   task automatic push_model();
      for (int orow = 0; orow <= int'(SH - SK); orow++)
         for (int ocol = 0; ocol <= int'(SW - SK); ocol++)
            for (int kr = 0; kr < int'(SK); kr++)
               for (int kc = 0; kc < int'(SK); kc++) begin
                  int   a;
                  logic lw, lf;
                  a  = (orow + kr) * int'(SW) + ocol + kc;
                  lw = (kr == int'(SK) - 1) && (kc == int'(SK) - 1);
                  lf = lw && (orow == int'(SH - SK)) && (ocol == int'(SW - SK));
                  exp_q.push_back({lf, lw, DW'(a)});
               end
   endtask

   // Must be entered just after a negedge; returns at the negedge where done_o is seen.
   task automatic run_small_pass(input int ready_pct, input bit pre_started, input bit poke,
                                 input bit restart, output int n_rx, output int first_hs,
                                 output int t0);
      logic [DW-1:0]  held_data;
      logic [SAW-1:0] held_addr;
      logic           held_lw, held_lf;
      logic [DW+1:0]  e;
      bit             stalled, finished;
      int             last_hs;
      stalled  = 0;
      finished = 0;
      n_rx     = 0;
      first_hs = -1;
      last_hs  = -1;
      push_model();
      if (!pre_started) s_start = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 4 * SPIX && !finished; i++) begin
         @(negedge clk);
         s_start = 1'b0;
         if (stalled) begin
            n_checks++;
            if (s_valid !== 1'b1 || s_data !== held_data || s_lw !== held_lw ||
                s_lf !== held_lf || s_addr !== held_addr) begin
               n_errors++;
               $display("FAIL stall_hold: got v=%b d=%0d lw=%b lf=%b a=%0d, want v=1 d=%0d lw=%b lf=%b a=%0d",
                        s_valid, s_data, s_lw, s_lf, s_addr, held_data, held_lw, held_lf,
                        held_addr);
            end
         end
         if (s_done === 1'b1) begin
            finished = 1;
            n_checks++;
            if (cyc != last_hs + 1 || n_rx != SPIX || s_busy !== 1'b0 || s_valid !== 1'b0) begin
               n_errors++;
               $display("FAIL done_pulse: got cyc=%0d n=%0d busy=%b valid=%b, want cyc=%0d n=%0d busy=0 valid=0",
                        cyc, n_rx, s_busy, s_valid, last_hs + 1, SPIX);
            end
            if (restart) s_start = 1'b1;
         end else begin
            s_ready = ($urandom_range(99) < ready_pct);
            if (poke && (n_rx == 30 || (s_valid && s_lf))) s_start = 1'b1;
            if (s_valid && s_ready) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_errors++;
                  $display("FAIL extra_pixel: got d=%0d, want no pixel", s_data);
               end else begin
                  e = exp_q.pop_front();
                  if ({s_lf, s_lw, s_data} !== e) begin
                     n_errors++;
                     $display("FAIL pixel_%0d: got lf=%b lw=%b d=%0d, want lf=%b lw=%b d=%0d",
                              n_rx, s_lf, s_lw, s_data, e[DW+1], e[DW], e[DW-1:0]);
                  end
               end
               if (n_rx < SPIX) rx_data[n_rx] = s_data;
               if (first_hs < 0) first_hs = cyc;
               last_hs = cyc;
               n_rx++;
            end
            stalled   = s_valid && !s_ready;
            held_data = s_data;
            held_addr = s_addr;
            held_lw   = s_lw;
            held_lf   = s_lf;
         end
      end
      n_checks++;
      if (!finished || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL pass_end: got finished=%0b left=%0d, want finished=1 left=0",
                  finished, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({s_busy, s_done, s_valid, s_lw, s_lf} !== 5'b0 || s_data !== '0 || s_addr !== '0 ||
          {d_busy, d_done, d_valid} !== 3'b0 || d_addr !== '0) begin
         n_errors++;
         $display("FAIL reset_init: got busy=%b done=%b valid=%b data=%0d addr=%0d, want all 0",
                  s_busy, s_done, s_valid, s_data, s_addr);
      end
      rst     = 1'b0;
      s_ready = 1'b1;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      repeat (40) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if ({s_busy, s_done, s_valid, s_lw, s_lf} !== 5'b0 || s_data !== '0 ||
             s_addr !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_%0d: got busy=%b done=%b valid=%b data=%0d addr=%0d, want all 0",
                     i, s_busy, s_done, s_valid, s_data, s_addr);
         end
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (s_done !== 1'b0 || s_busy !== 1'b0 || s_valid !== 1'b0 || s_addr !== '0) begin
            n_errors++;
            $display("FAIL reset_after: got done=%b busy=%b valid=%b addr=%0d, want 0 0 0 0",
                     s_done, s_busy, s_valid, s_addr);
         end
      end
   endtask

   task automatic test_ready_high();
      int n, f, t0;
      run_small_pass(100, 0, 0, 0, n, f, t0);
      n_checks++;
      if (f != t0 + 2) begin
         n_errors++;
         $display("FAIL first_latency: got cyc %0d, want %0d", f, t0 + 2);
      end
      n_checks++;
      if (cyc - f != SPIX) begin
         n_errors++;
         $display("FAIL no_bubbles: got span %0d, want %0d", cyc - f, SPIX);
      end
      n_checks++;
      if (rx_data[4] !== 32'd4 || rx_data[5] !== 32'd6 || rx_data[24] !== 32'd28 ||
          rx_data[25] !== 32'd1 || rx_data[99] !== 32'd35) begin
         n_errors++;
         $display("FAIL window_addrs: got %0d %0d %0d %0d %0d, want 4 6 28 1 35",
                  rx_data[4], rx_data[5], rx_data[24], rx_data[25], rx_data[99]);
      end
      @(negedge clk);
      n_checks++;
      if (s_done !== 1'b0 || s_busy !== 1'b0) begin
         n_errors++;
         $display("FAIL done_width: got done=%b busy=%b, want 0 0", s_done, s_busy);
      end
   endtask

   task automatic test_ready_random();
      int n, f, t0;
      @(negedge clk);
      run_small_pass(50, 0, 0, 0, n, f, t0);
      n_checks++;
      if (n != SPIX) begin
         n_errors++;
         $display("FAIL random_count: got %0d, want %0d", n, SPIX);
      end
   endtask

   task automatic test_start_ignored();
      int n, f, t0;
      @(negedge clk);
      run_small_pass(70, 0, 1, 0, n, f, t0);
      n_checks++;
      if (n != SPIX) begin
         n_errors++;
         $display("FAIL poke_count: got %0d, want %0d", n, SPIX);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (s_busy !== 1'b0 || s_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL poke_idle: got busy=%b valid=%b, want 0 0", s_busy, s_valid);
      end
   endtask

   task automatic test_back_to_back();
      int n, f, t0;
      @(negedge clk);
      s_ready = 1'b1;
      run_small_pass(100, 0, 0, 1, n, f, t0);
      run_small_pass(100, 1, 0, 0, n, f, t0);
      n_checks++;
      if (n != SPIX || f != t0 + 2) begin
         n_errors++;
         $display("FAIL restart: got n=%0d first=%0d, want n=%0d first=%0d", n, f, SPIX, t0 + 2);
      end
   endtask

   task automatic test_drain_stall();
      bit found;
      found = 0;
      @(negedge clk);
      s_ready = 1'b1;
      s_start = 1'b1;
      for (int i = 0; i < 4 * SPIX && !found; i++) begin
         @(negedge clk);
         s_start = 1'b0;
         if (s_valid && s_lf) found = 1;
      end
      n_checks++;
      if (!found) begin
         n_errors++;
         $display("FAIL drain_reach: got no last-frame pixel, want one");
      end
      s_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++;
         if (s_valid !== 1'b1 || s_data !== 32'd35 || s_lf !== 1'b1 || s_busy !== 1'b1 ||
             s_done !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_hold_%0d: got v=%b d=%0d lf=%b busy=%b done=%b, want 1 35 1 1 0",
                     i, s_valid, s_data, s_lf, s_busy, s_done);
         end
      end
      s_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (s_done !== 1'b1 || s_busy !== 1'b0 || s_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL drain_done: got done=%b busy=%b valid=%b, want 1 0 0",
                  s_done, s_busy, s_valid);
      end
   endtask

   task automatic test_defaults();
      int n, nlw, nlf, t0, done_cyc;
      logic [DW-1:0] last;
      n = 0;
      nlw = 0;
      nlf = 0;
      done_cyc = -1;
      last = '0;
      @(negedge clk);
      d_ready = 1'b1;
      d_start = 1'b1;
      t0 = cyc;
      for (int i = 0; i < DPIX + 100 && done_cyc < 0; i++) begin
         @(negedge clk);
         d_start = 1'b0;
         if (d_done === 1'b1) begin
            done_cyc = cyc;
         end else if (d_valid === 1'b1) begin
            n++;
            if (d_lw) nlw++;
            if (d_lf) begin
               nlf++;
               last = d_data;
            end
         end
      end
      n_checks++;
      if (n != DPIX || nlw != 784 || nlf != 1) begin
         n_errors++;
         $display("FAIL dflt_count: got n=%0d lw=%0d lf=%0d, want %0d 784 1", n, nlw, nlf, DPIX);
      end
      n_checks++;
      if (last !== 32'd1023) begin
         n_errors++;
         $display("FAIL dflt_last_addr: got %0d, want 1023", last);
      end
      n_checks++;
      if (done_cyc - t0 != DPIX + 2) begin
         n_errors++;
         $display("FAIL dflt_latency: got %0d, want %0d", done_cyc - t0, DPIX + 2);
      end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_ready_high();
      test_ready_random();
      test_start_ignored();
      test_back_to_back();
      test_drain_stall();
      test_defaults();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
